// File: rtl/issue_select.sv
// Issue queue with tag wakeup and age-ordered select of ALU pair, MULT and ADDR packages,
// plus mispredict squash of entries younger than the branch in ROB order.
module issue_select #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    mult_fun_rdy,
    input  logic                    mis_pred,
    input  logic [5:0]              mis_pred_indx,
    input  logic [5:0]              rob_head,
    input  logic                    ins_valid,
    input  logic [1:0]              ins_fu,
    input  logic [65:0]             ins_pkg,
    input  logic [TAG_W-1:0]        ins_src1_tag,
    input  logic [TAG_W-1:0]        ins_src2_tag,
    input  logic                    ins_src1_rdy,
    input  logic                    ins_src2_rdy,
    input  logic                    wake0_vld,
    input  logic [TAG_W-1:0]        wake0_tag,
    input  logic                    wake1_vld,
    input  logic [TAG_W-1:0]        wake1_tag,
    output logic                    iq_full,
    output logic [$clog2(DEPTH):0]  iq_count,
    output logic [65:0]             alu1_inst_pkg_out,
    output logic [65:0]             alu2_inst_pkg_out,
    output logic [65:0]             mult_inst_pkg_out,
    output logic [65:0]             addr_inst_pkg_out
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [1:0] FU_ALU  = 2'd0;
    localparam logic [1:0] FU_MULT = 2'd1;
    localparam logic [1:0] FU_ADDR = 2'd2;
    localparam logic [1:0] FU_RSVD = 2'd3;

    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] s1_rdy;
    logic [DEPTH-1:0] s2_rdy;
    logic [1:0]       ent_fu  [DEPTH];
    logic [65:0]      ent_pkg [DEPTH];
    logic [TAG_W-1:0] ent_t1  [DEPTH];
    logic [TAG_W-1:0] ent_t2  [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic             full_q;

    // Distance from the ROB head, modulo 64: smaller means older.
    function automatic logic [5:0] rob_age(input logic [5:0] idx, input logic [5:0] head);
        return idx - head;
    endfunction

    function automatic logic woken(input logic [TAG_W-1:0] tag,
                                   input logic v0, input logic [TAG_W-1:0] t0,
                                   input logic v1, input logic [TAG_W-1:0] t1);
        return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
    endfunction

    logic [DEPTH-1:0] rdy;
    logic [5:0]       age [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age[i] = rob_age(ent_pkg[i][64:59], rob_head);
            rdy[i] = ent_vld[i] && s1_rdy[i] && s2_rdy[i];
        end
    end

    logic             alu1_hit, alu2_hit, mult_hit, addr_hit;
    logic [IDX_W-1:0] alu1_idx, alu2_idx, mult_idx, addr_idx;
    logic [5:0]       alu1_age, alu2_age, mult_age, addr_age;

    always_comb begin
        alu1_hit = 1'b0; alu1_idx = '0; alu1_age = '0;
        alu2_hit = 1'b0; alu2_idx = '0; alu2_age = '0;
        mult_hit = 1'b0; mult_idx = '0; mult_age = '0;
        addr_hit = 1'b0; addr_idx = '0; addr_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i] && ent_fu[i] == FU_ALU && (!alu1_hit || age[i] < alu1_age)) begin
                alu1_hit = 1'b1; alu1_idx = IDX_W'(i); alu1_age = age[i];
            end
            if (rdy[i] && ent_fu[i] == FU_MULT && (!mult_hit || age[i] < mult_age)) begin
                mult_hit = 1'b1; mult_idx = IDX_W'(i); mult_age = age[i];
            end
            if (rdy[i] && ent_fu[i] == FU_ADDR && (!addr_hit || age[i] < addr_age)) begin
                addr_hit = 1'b1; addr_idx = IDX_W'(i); addr_age = age[i];
            end
        end
        // Second pass: oldest ALU op other than the one already picked for alu1.
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i] && ent_fu[i] == FU_ALU && !(alu1_hit && alu1_idx == IDX_W'(i)) &&
                (!alu2_hit || age[i] < alu2_age)) begin
                alu2_hit = 1'b1; alu2_idx = IDX_W'(i); alu2_age = age[i];
            end
        end
    end

    assign alu1_inst_pkg_out = (alu1_hit && !mis_pred) ? ent_pkg[alu1_idx] : '0;
    assign alu2_inst_pkg_out = (alu2_hit && !mis_pred) ? ent_pkg[alu2_idx] : '0;
    assign mult_inst_pkg_out = (mult_hit && !mis_pred) ? ent_pkg[mult_idx] : '0;
    assign addr_inst_pkg_out = (addr_hit && !mis_pred) ? ent_pkg[addr_idx] : '0;

    logic [DEPTH-1:0] iss_mask;
    logic [DEPTH-1:0] sq_mask;
    logic [5:0]       br_age;

    always_comb begin
        iss_mask = '0;
        if (!mis_pred) begin
            if (!stall) begin
                if (alu1_hit) iss_mask[alu1_idx] = 1'b1;
                if (alu2_hit) iss_mask[alu2_idx] = 1'b1;
                if (addr_hit) iss_mask[addr_idx] = 1'b1;
            end
            if (mult_fun_rdy && mult_hit) iss_mask[mult_idx] = 1'b1;
        end
    end

    assign br_age = rob_age(mis_pred_indx, rob_head);

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            sq_mask[i] = mis_pred && ent_vld[i] && (age[i] > br_age);
    end

    logic             ins_hit;
    logic [IDX_W-1:0] ins_idx;
    logic             ins_we;

    always_comb begin
        ins_hit = 1'b0;
        ins_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_vld[i]) begin
                ins_hit = 1'b1;
                ins_idx = IDX_W'(i);
            end
        end
    end

    // Acceptance uses the registered full flag, so slots freed this cycle are not reused until next.
    assign ins_we = ins_valid && !full_q && !mis_pred && (ins_fu != FU_RSVD) && ins_hit;

    logic [DEPTH-1:0] vld_nxt, s1_nxt, s2_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        vld_nxt = (ent_vld & ~iss_mask & ~sq_mask) | (ins_we ? (DEPTH'(1) << ins_idx) : '0);
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt   = cnt_nxt + CNT_W'(vld_nxt[i]);
            s1_nxt[i] = s1_rdy[i] | woken(ent_t1[i], wake0_vld, wake0_tag, wake1_vld, wake1_tag);
            s2_nxt[i] = s2_rdy[i] | woken(ent_t2[i], wake0_vld, wake0_tag, wake1_vld, wake1_tag);
            if (ins_we && ins_idx == IDX_W'(i)) begin
                s1_nxt[i] = ins_src1_rdy |
                            woken(ins_src1_tag, wake0_vld, wake0_tag, wake1_vld, wake1_tag);
                s2_nxt[i] = ins_src2_rdy |
                            woken(ins_src2_tag, wake0_vld, wake0_tag, wake1_vld, wake1_tag);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld <= '0;
            s1_rdy  <= '0;
            s2_rdy  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            ent_vld <= vld_nxt;
            s1_rdy  <= s1_nxt;
            s2_rdy  <= s2_nxt;
            cnt_q   <= cnt_nxt;
            full_q  <= (cnt_nxt == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (ins_we) begin
            ent_fu[ins_idx]  <= ins_fu;
            ent_pkg[ins_idx] <= ins_pkg | {1'b1, 65'd0};
            ent_t1[ins_idx]  <= ins_src1_tag;
            ent_t2[ins_idx]  <= ins_src2_tag;
        end
    end

    assign iq_full  = full_q;
    assign iq_count = cnt_q;

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select: stimulus queues expected issues, a negedge monitor pops
// and compares each accepted package together with its issue cycle.
module tb_issue_select;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        mult_fun_rdy = 1'b1;
    logic        mis_pred = 1'b0;
    logic [5:0]  mis_pred_indx = '0;
    logic [5:0]  rob_head = '0;
    logic        ins_valid = 1'b0;
    logic [1:0]  ins_fu = '0;
    logic [65:0] ins_pkg = '0;
    logic [5:0]  ins_src1_tag = '0, ins_src2_tag = '0;
    logic        ins_src1_rdy = 1'b0, ins_src2_rdy = 1'b0;
    logic        wake0_vld = 1'b0, wake1_vld = 1'b0;
    logic [5:0]  wake0_tag = '0, wake1_tag = '0;
    logic        iq_full;
    logic [4:0]  iq_count;
    logic [65:0] alu1_out, alu2_out, mult_out, addr_out;

    issue_select #(.DEPTH(16), .TAG_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .mult_fun_rdy(mult_fun_rdy),
        .mis_pred(mis_pred), .mis_pred_indx(mis_pred_indx), .rob_head(rob_head),
        .ins_valid(ins_valid), .ins_fu(ins_fu), .ins_pkg(ins_pkg),
        .ins_src1_tag(ins_src1_tag), .ins_src2_tag(ins_src2_tag),
        .ins_src1_rdy(ins_src1_rdy), .ins_src2_rdy(ins_src2_rdy),
        .wake0_vld(wake0_vld), .wake0_tag(wake0_tag),
        .wake1_vld(wake1_vld), .wake1_tag(wake1_tag),
        .iq_full(iq_full), .iq_count(iq_count),
        .alu1_inst_pkg_out(alu1_out), .alu2_inst_pkg_out(alu2_out),
        .mult_inst_pkg_out(mult_out), .addr_inst_pkg_out(addr_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [65:0] pkg; int cyc; } exp_t;
    exp_t q_alu1[$], q_alu2[$], q_mult[$], q_addr[$];
    int n_checks = 0;
    int n_fail = 0;

    localparam logic [1:0] ALU = 2'd0, MULT = 2'd1, ADDR = 2'd2, RSVD = 2'd3;

    function automatic logic [65:0] mk(input logic [5:0] rob);
        logic [58:0] pl;
        pl = 59'h5A5_0000_0000 ^ {53'd0, rob};
        return {1'b1, rob, pl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [1:0] fu, input logic [5:0] rob,
                       input logic [5:0] t1, input logic r1,
                       input logic [5:0] t2, input logic r2);
        logic [65:0] p;
        p = mk(rob);
        ins_valid = 1'b1; ins_fu = fu; ins_pkg = {1'b0, p[64:0]};
        ins_src1_tag = t1; ins_src1_rdy = r1;
        ins_src2_tag = t2; ins_src2_rdy = r2;
    endtask

    task automatic ins_off();
        ins_valid = 1'b0;
    endtask

    task automatic expect_issue(input int p, input logic [5:0] rob, input int c);
        exp_t e;
        e.pkg = mk(rob);
        e.cyc = c;
        case (p)
            0: q_alu1.push_back(e);
            1: q_alu2.push_back(e);
            2: q_mult.push_back(e);
            default: q_addr.push_back(e);
        endcase
    endtask

    task automatic chk(input string name, input logic [65:0] got, input logic [65:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endtask

    task automatic mon_port(input int p, input logic [65:0] got);
        exp_t e;
        logic have;
        have = 1'b0;
        e.pkg = '0;
        e.cyc = 0;
        case (p)
            0: if (q_alu1.size() > 0) begin e = q_alu1.pop_front(); have = 1'b1; end
            1: if (q_alu2.size() > 0) begin e = q_alu2.pop_front(); have = 1'b1; end
            2: if (q_mult.size() > 0) begin e = q_mult.pop_front(); have = 1'b1; end
            default: if (q_addr.size() > 0) begin e = q_addr.pop_front(); have = 1'b1; end
        endcase
        n_checks++;
        if (!have) begin
            n_fail++;
            $display("FAIL unexpected_issue port %0d cycle %0d: got %h expected no issue", p, cyc, got);
        end else if (got !== e.pkg || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL issue port %0d: got %h at cycle %0d expected %h at cycle %0d",
                     p, got, cyc, e.pkg, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mis_pred) begin
                n_checks++;
                if ((alu1_out | alu2_out | mult_out | addr_out) != 66'd0) begin
                    n_fail++;
                    $display("FAIL mispredict_outputs cycle %0d: got %h %h %h %h expected all 0",
                             cyc, alu1_out, alu2_out, mult_out, addr_out);
                end
            end else begin
                if (alu1_out[65] && !stall)     mon_port(0, alu1_out);
                if (alu2_out[65] && !stall)     mon_port(1, alu2_out);
                if (mult_out[65] && mult_fun_rdy) mon_port(2, mult_out);
                if (addr_out[65] && !stall)     mon_port(3, addr_out);
            end
        end
    end

    initial begin
        int left;
        // Reset state
        tick(); tick();
        chk("reset_count", 66'(iq_count), 66'd0);
        chk("reset_full", 66'(iq_full), 66'd0);
        chk("reset_alu1", alu1_out, 66'd0);
        chk("reset_mult", mult_out, 66'd0);
        rst_n = 1'b1;
        tick();

        // Three ALU ops collected under stall, then oldest two issue together
        stall = 1'b1; ins(ALU, 6'd5, 6'd0, 1'b1, 6'd0, 1'b1);
        tick(); ins(ALU, 6'd3, 6'd0, 1'b1, 6'd0, 1'b1);
        tick(); ins(ALU, 6'd7, 6'd0, 1'b1, 6'd0, 1'b1);
        tick(); ins_off(); stall = 1'b0;
        chk("alu_count3", 66'(iq_count), 66'd3);
        expect_issue(0, 6'd3, cyc); expect_issue(1, 6'd5, cyc); expect_issue(0, 6'd7, cyc + 1);
        tick(); chk("alu_count1", 66'(iq_count), 66'd1);
        tick(); chk("alu_count0", 66'(iq_count), 66'd0);

        // MULT held while the multiplier is busy
        mult_fun_rdy = 1'b0; ins(MULT, 6'd9, 6'd0, 1'b1, 6'd0, 1'b1);
        tick(); ins_off();
        repeat (4) begin
            chk("mult_held_pkg", mult_out, mk(6'd9));
            chk("mult_held_count", 66'(iq_count), 66'd1);
            tick();
        end
        mult_fun_rdy = 1'b1; expect_issue(2, 6'd9, cyc);
        tick(); chk("mult_freed_count", 66'(iq_count), 66'd0);

        // Wakeup: eligible the cycle after the broadcast
        ins(ALU, 6'd10, 6'd12, 1'b0, 6'd0, 1'b1);
        tick(); ins_off();
        chk("not_ready_alu1", alu1_out, 66'd0);
        wake0_vld = 1'b1; wake0_tag = 6'd12; expect_issue(0, 6'd10, cyc + 1);
        tick(); wake0_vld = 1'b0;
        // Insert whose source is broadcast in the same cycle is stored ready
        ins(ALU, 6'd11, 6'd0, 1'b1, 6'd20, 1'b0);
        wake1_vld = 1'b1; wake1_tag = 6'd20; expect_issue(0, 6'd11, cyc + 1);
        tick(); ins_off(); wake1_vld = 1'b0;
        tick(); chk("wake_count0", 66'(iq_count), 66'd0);

        // Mispredict squash across the ROB index wrap
        stall = 1'b1; rob_head = 6'd60;
        ins(ALU, 6'd61, 6'd0, 1'b1, 6'd0, 1'b1); tick();
        ins(ALU, 6'd62, 6'd0, 1'b1, 6'd0, 1'b1); tick();
        ins(ALU, 6'd1, 6'd0, 1'b1, 6'd0, 1'b1);  tick();
        ins(ALU, 6'd2, 6'd0, 1'b1, 6'd0, 1'b1);  tick();
        chk("pre_squash_count", 66'(iq_count), 66'd4);
        ins(ALU, 6'd3, 6'd0, 1'b1, 6'd0, 1'b1);
        mis_pred = 1'b1; mis_pred_indx = 6'd62;
        tick(); mis_pred = 1'b0; ins_off();
        chk("post_squash_count", 66'(iq_count), 66'd2);
        stall = 1'b0; expect_issue(0, 6'd61, cyc); expect_issue(1, 6'd62, cyc);
        tick(); chk("squash_drain_count", 66'(iq_count), 66'd0);
        rob_head = 6'd0;

        // Fill to DEPTH, check full behaviour and slot reuse timing
        stall = 1'b1;
        ins(ADDR, 6'd20, 6'd0, 1'b1, 6'd0, 1'b1); tick();
        for (int r = 21; r <= 35; r++) begin
            ins(ADDR, 6'(r), 6'd40, 1'b0, 6'd0, 1'b1); tick();
        end
        chk("fill_full", 66'(iq_full), 66'd1);
        chk("fill_count", 66'(iq_count), 66'd16);
        ins(ALU, 6'd50, 6'd0, 1'b1, 6'd0, 1'b1);
        tick();
        chk("full_ignore_full", 66'(iq_full), 66'd1);
        chk("full_ignore_count", 66'(iq_count), 66'd16);
        stall = 1'b0; expect_issue(3, 6'd20, cyc);
        tick();
        chk("after_issue_full", 66'(iq_full), 66'd0);
        chk("after_issue_count", 66'(iq_count), 66'd15);
        expect_issue(0, 6'd50, cyc + 1);
        wake0_vld = 1'b1; wake0_tag = 6'd40;
        for (int k = 0; k < 15; k++) expect_issue(3, 6'(21 + k), cyc + 1 + k);
        tick(); ins_off(); wake0_vld = 1'b0;
        chk("refill_full", 66'(iq_full), 66'd1);
        chk("refill_count", 66'(iq_count), 66'd16);
        repeat (16) tick();
        chk("drain_count", 66'(iq_count), 66'd0);
        chk("drain_full", 66'(iq_full), 66'd0);

        // Stall holds ALU/ADDR while MULT still issues
        stall = 1'b1;
        ins(ALU, 6'd40, 6'd0, 1'b1, 6'd0, 1'b1);  tick();
        ins(ADDR, 6'd41, 6'd0, 1'b1, 6'd0, 1'b1); tick();
        ins(MULT, 6'd42, 6'd0, 1'b1, 6'd0, 1'b1); expect_issue(2, 6'd42, cyc + 1);
        tick(); ins_off();
        tick();
        chk("stall_count", 66'(iq_count), 66'd2);
        chk("stall_alu1_pkg", alu1_out, mk(6'd40));
        chk("stall_addr_pkg", addr_out, mk(6'd41));
        chk("stall_mult_gone", mult_out, 66'd0);
        stall = 1'b0; expect_issue(0, 6'd40, cyc); expect_issue(3, 6'd41, cyc);
        tick(); chk("stall_drain_count", 66'(iq_count), 66'd0);

        // Reserved FU code is not stored
        ins(RSVD, 6'd44, 6'd0, 1'b1, 6'd0, 1'b1);
        tick(); ins_off();
        tick(); chk("rsvd_count", 66'(iq_count), 66'd0);

        // Asynchronous reset in the middle of a cycle
        stall = 1'b1; ins(ALU, 6'd45, 6'd0, 1'b1, 6'd0, 1'b1);
        tick(); ins_off();
        chk("pre_rst_alu1", alu1_out, mk(6'd45));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_alu1", alu1_out, 66'd0);
        chk("async_rst_count", 66'(iq_count), 66'd0);
        tick(); rst_n = 1'b1; stall = 1'b0;
        repeat (3) tick();

        left = q_alu1.size() + q_alu2.size() + q_mult.size() + q_addr.size();
        chk("pending_issues", 66'(left), 66'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
